// File: rtl/strobe_to_pulse_if.sv
// strobe_to_pulse_if: strobe request and pulse status bundle
interface strobe_to_pulse_if #(
  parameter int PEND_W = 3
);
  logic in_strobe;
  logic in_clear_overflow;
  logic out_signal;
  logic out_busy;
  logic [PEND_W-1:0] out_pending;
  logic out_overflow;
  modport master (
    output in_strobe, in_clear_overflow,
    input  out_signal, out_busy, out_pending, out_overflow
  );
  modport slave (
    input  in_strobe, in_clear_overflow,
    output out_signal, out_busy, out_pending, out_overflow
  );
endinterface

// File: rtl/strobe_to_pulse.sv
// strobe_to_pulse: turns single-cycle strobes into fixed-width pulses with a guaranteed low gap and a saturating queue
module strobe_to_pulse #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_DEPTH  = 7,
  parameter int PEND_W      = 3
) (
  input logic in_clock,
  input logic in_reset_n,
  strobe_to_pulse_if.slave bus
);
  localparam int MAX_C = HIGH_CYCLES > GAP_CYCLES ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CNT_W = MAX_C > 1 ? $clog2(MAX_C) : 1;
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] DEPTH = PEND_W'(PEND_DEPTH);
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic sig_q, sig_d, busy_q, busy_d, ovf_q, ovf_d;
  logic acc, hi_end, last_gap, drop;
  always_comb begin
    acc = bus.in_strobe && state_q != IDLE;
    hi_end = state_q == HIGH && cnt_q == HIGH_LAST;
    last_gap = state_q == GAP && cnt_q == GAP_LAST;
    drop = acc && !last_gap && pend_q == DEPTH;
    state_d = state_q == IDLE ? (bus.in_strobe ? HIGH : IDLE) :
              hi_end ? GAP :
              last_gap ? ((acc || pend_q != '0) ? HIGH : IDLE) : state_q;
    cnt_d = (state_q == IDLE || hi_end || last_gap) ? '0 : cnt_q + 1'b1;
    pend_d = last_gap ? ((acc || pend_q == '0) ? pend_q : pend_q - 1'b1) :
             (acc && pend_q != DEPTH) ? pend_q + 1'b1 : pend_q;
    ovf_d = drop || (ovf_q && !bus.in_clear_overflow);
    sig_d = state_d == HIGH;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= '0;
      sig_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      sig_q <= sig_d;
      busy_q <= busy_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.out_signal = sig_q;
  assign bus.out_busy = busy_q;
  assign bus.out_pending = pend_q;
  assign bus.out_overflow = ovf_q;
endmodule

// File: tb/tb_strobe_to_pulse.sv
// tb_strobe_to_pulse: directed scenarios checked against a cycle model through a scoreboard queue
module tb_strobe_to_pulse;
  localparam int H = 4, G = 2, D = 7, W = 3;
  logic in_clock = 1'b0;
  logic in_reset_n = 1'b0;
  strobe_to_pulse_if #(.PEND_W(W)) bus ();
  strobe_to_pulse #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_DEPTH(D), .PEND_W(W)) dut (
    .in_clock(in_clock),
    .in_reset_n(in_reset_n),
    .bus(bus)
  );
  always #5 in_clock = ~in_clock;
  typedef struct packed {logic sig; logic busy; logic [W-1:0] pend; logic ovf;} exp_t;
  exp_t sb[$];
  int checks = 0, passed = 0;
  int m_phase = 0, m_left = 0, m_pend = 0, m_acc = 0, m_starts = 0;
  bit m_ovf = 0;
  int edges = 0, bad_hi = 0, bad_lo = 0, hi_run = 0, lo_run = 99;
  logic prev = 1'b0;
  logic sig_at [0:40];
  int pend_at [0:40];
  int pmax;
  always @(negedge in_clock) begin
    if (!in_reset_n) begin
      prev = 1'b0;
      hi_run = 0;
      lo_run = 99;
    end else begin
      if (bus.out_signal && !prev) begin
        edges++;
        if (lo_run < G) bad_lo++;
        hi_run = 0;
      end
      if (!bus.out_signal && prev) begin
        if (hi_run != H) bad_hi++;
        lo_run = 0;
      end
      if (bus.out_signal) hi_run++;
      else lo_run++;
      prev = bus.out_signal;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic model_step(input bit s, input bit c);
    int tot;
    bit drop;
    drop = 0;
    tot = m_pend + ((s && m_phase != 0) ? 1 : 0);
    if (m_phase == 0) begin
      if (s) begin
        m_phase = 1;
        m_left = H;
        m_acc++;
        m_starts++;
      end
    end else if (m_phase == 2 && m_left == 1) begin
      if (s) m_acc++;
      if (tot > 0) begin
        m_pend = tot - 1;
        m_phase = 1;
        m_left = H;
        m_starts++;
      end else m_phase = 0;
    end else begin
      if (tot > D) drop = 1;
      else begin
        m_pend = tot;
        if (s) m_acc++;
      end
      if (m_phase == 1 && m_left == 1) begin
        m_phase = 2;
        m_left = G;
      end else m_left--;
    end
    if (c) m_ovf = 0;
    if (drop) m_ovf = 1;
  endtask
  task automatic cycle(input bit s, input bit c);
    exp_t e;
    bus.in_strobe = s;
    bus.in_clear_overflow = c;
    model_step(s, c);
    e.sig = m_phase == 1;
    e.busy = m_phase != 0;
    e.pend = W'(m_pend);
    e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge in_clock);
    #1;
    e = sb.pop_front();
    chk("sb_sig", bus.out_signal, e.sig);
    chk("sb_busy", bus.out_busy, e.busy);
    chk("sb_pend", bus.out_pending, e.pend);
    chk("sb_ovf", bus.out_overflow, e.ovf);
  endtask
  initial begin
    bus.in_strobe = 1'b0;
    bus.in_clear_overflow = 1'b0;
    repeat (3) @(posedge in_clock);
    #1;
    chk("rst_sig", bus.out_signal, 0);
    chk("rst_busy", bus.out_busy, 0);
    chk("rst_pend", bus.out_pending, 0);
    chk("rst_ovf", bus.out_overflow, 0);
    in_reset_n = 1'b1;
    repeat (10) cycle(0, 0);
    cycle(1, 0);
    for (int c = 11; c <= 18; c++) begin
      chk("s1_sig", bus.out_signal, c <= 14);
      chk("s1_busy", bus.out_busy, c <= 16);
      chk("s1_pend", bus.out_pending, 0);
      cycle(0, 0);
    end
    repeat (2) cycle(0, 0);
    for (int c = 10; c <= 30; c++) begin
      cycle(c == 10 || c == 12 || c == 13, 0);
      sig_at[c+1] = bus.out_signal;
      pend_at[c+1] = int'(bus.out_pending);
    end
    pmax = 0;
    for (int c = 11; c <= 30; c++) begin
      chk("s2_sig", sig_at[c], (c >= 11 && c <= 14) || (c >= 17 && c <= 20) || (c >= 23 && c <= 26));
      if (pend_at[c] > pmax) pmax = pend_at[c];
    end
    chk("s2_pend_peak", pmax, 2);
    chk("s2_pend_17", pend_at[17], 1);
    chk("s2_pend_23", pend_at[23], 0);
    chk("s2_edges", edges, m_acc);
    repeat (2) cycle(0, 0);
    pmax = 0;
    for (int c = 10; c <= 21; c++) begin
      cycle(1, 0);
      if (c == 10) chk("s3_first", bus.out_signal, 1);
      if (int'(bus.out_pending) > pmax) pmax = int'(bus.out_pending);
    end
    chk("s3_pend_sat", pmax, D);
    chk("s3_ovf", bus.out_overflow, 1);
    for (int i = 0; i < 100 && m_phase != 0; i++) cycle(0, 0);
    chk("s3_idle", bus.out_busy, 0);
    chk("s3_edges", edges, m_acc);
    chk("s3_hi_width", bad_hi, 0);
    chk("s3_lo_gap", bad_lo, 0);
    for (int i = 0; i < 60 && !(m_pend == D && m_phase == 1 && m_left >= 2); i++)
      cycle(m_pend < D && !(m_phase == 2 && m_left == 1), 0);
    chk("s4_fill_pend", bus.out_pending, D);
    chk("s5_ovf_pre", bus.out_overflow, 1);
    cycle(0, 1);
    chk("s5_clear", bus.out_overflow, 0);
    chk("s5_clear_pend", bus.out_pending, D);
    for (int i = 0; i < 20 && !(m_phase == 2 && m_left == 1); i++) cycle(0, 0);
    chk("s4_at_gap", bus.out_signal, 0);
    cycle(1, 0);
    chk("s4_full_pend", bus.out_pending, D);
    chk("s4_full_ovf", bus.out_overflow, 0);
    chk("s4_next_high", bus.out_signal, 1);
    cycle(1, 1);
    chk("s5_set_wins", bus.out_overflow, 1);
    for (int i = 0; i < 100 && m_phase != 0; i++) cycle(0, 0);
    chk("s5_idle", bus.out_busy, 0);
    chk("s5_edges", edges, m_acc);
    repeat (5) cycle(1, 0);
    repeat (3) cycle(0, 0);
    chk("s6_pre_pend", bus.out_pending, 3);
    chk("s6_pre_sig", bus.out_signal, 1);
    chk("s6_pre_ovf", bus.out_overflow, 1);
    in_reset_n = 1'b0;
    #1;
    chk("s6_rst_sig", bus.out_signal, 0);
    chk("s6_rst_busy", bus.out_busy, 0);
    chk("s6_rst_pend", bus.out_pending, 0);
    chk("s6_rst_ovf", bus.out_overflow, 0);
    m_phase = 0;
    m_pend = 0;
    m_ovf = 0;
    m_acc = m_starts;
    @(posedge in_clock);
    #1;
    in_reset_n = 1'b1;
    cycle(1, 0);
    chk("s6_latency", bus.out_signal, 1);
    for (int i = 0; i < 40 && m_phase != 0; i++) cycle(0, 0);
    chk("s6_idle", bus.out_busy, 0);
    chk("s6_edges", edges, m_acc);
    chk("s6_hi_width", bad_hi, 0);
    chk("s6_lo_gap", bad_lo, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
